// File: rtl/render_pkg.sv
// Shared render-path definitions: default framebuffer geometry, the transparent key colour,
// and the pixel entry carried from the tile renderer toward VRAM.
package render_pkg;

  localparam int RENDER_ADDR_W = 19;
  localparam int RENDER_DATA_W = 16;
  localparam logic [RENDER_DATA_W-1:0] RENDER_KEY_COLOR = 16'hF81F;

  typedef struct packed {
    logic [RENDER_ADDR_W-1:0] addr;
    logic [RENDER_DATA_W-1:0] data;
  } pixel_entry_t;

endpackage

// File: rtl/fb_fifo.sv
// Synchronous FIFO holding pixel entries. Pointers carry one extra wrap bit so that
// full and empty stay distinct. The head reads as zero whenever the FIFO is empty.
module fb_fifo #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 35
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_entry,
  output logic [ENTRY_W-1:0]       rd_entry,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   rd_ptr;

  // The storage array carries no reset; its contents are masked until level says otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LVL_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LVL_W'(1);
      end
    end
  end

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign rd_entry = (level != '0) ? mem[rd_ptr[PTR_W-1:0]] : '0;

endmodule

// File: rtl/fb_write_buffer.sv
// Pixel write buffer between the tile renderer and VRAM, with a sticky overflow flag.
// Defining FB_COLOR_KEY_EN drops writes whose colour equals KEY_COLOR before they are stored.
module fb_write_buffer
  import render_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = RENDER_ADDR_W,
  parameter int                DATA_W    = RENDER_DATA_W,
  parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(RENDER_KEY_COLOR)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_wr,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   idle
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

`ifdef FB_COLOR_KEY_EN
  localparam logic KEY_FILTER = 1'b1;
`else
  localparam logic KEY_FILTER = 1'b0;
`endif

  logic               key_drop;
  logic               pop;
  logic               push;
  logic               full;
  logic [ENTRY_W-1:0] head;

  assign key_drop  = KEY_FILTER && (in_data == KEY_COLOR);
  assign out_valid = (level != '0);
  assign idle      = (level == '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push      = in_wr && !key_drop && (!full || pop);

  fb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .wr_entry ({in_addr, in_data}),
    .rd_entry (head),
    .level    (level),
    .full     (full)
  );

  assign {out_addr, out_data} = head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (in_wr && !key_drop && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_buffer.sv
// Directed bench for fb_write_buffer: reset, latency, fill/overflow, hold, drain,
// concurrent push/pop, colour key and mid-operation reset.
module tb_fb_write_buffer;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [18:0] in_addr;
  logic [15:0] in_data;
  logic        in_wr;
  logic [18:0] out_addr;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        idle;

  int compared   = 0;
  int mismatched = 0;

  fb_write_buffer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [18:0] addr, input logic [15:0] data,
                                input logic rdy);
    in_wr     = wr;
    in_addr   = addr;
    in_data   = data;
    out_ready = rdy;
  endtask

  initial begin
    rstn = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0);
    #12;
    check_output("rst_level", 32'(level), 0);
    check_output("rst_valid", 32'(out_valid), 0);
    check_output("rst_overflow", 32'(overflow), 0);
    check_output("rst_idle", 32'(idle), 1);
    check_output("rst_addr", 32'(out_addr), 0);
    check_output("rst_data", 32'(out_data), 0);
    tick();
    rstn = 1'b1;
    tick();

    // Single write appears one cycle later, then drains.
    apply_stimulus(1'b1, 19'h00010, 16'h1234, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("lat_valid", 32'(out_valid), 1);
    check_output("lat_addr", 32'(out_addr), 32'h10);
    check_output("lat_data", 32'(out_data), 32'h1234);
    check_output("lat_idle_busy", 32'(idle), 0);
    tick();
    check_output("lat_idle", 32'(idle), 1);
    check_output("lat_valid_off", 32'(out_valid), 0);

    // Fill to capacity with VRAM stalled.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 19'(i), 16'hA000 + 16'(i), 1'b0);
      tick();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0);
    check_output("fill_level", 32'(level), 16);
    check_output("fill_overflow", 32'(overflow), 0);

    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("hold_addr", 32'(out_addr), 0);
      check_output("hold_data", 32'(out_data), 32'hA000);
    end

    apply_stimulus(1'b1, 19'h00099, 16'hBEEF, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0);
    check_output("drop_level", 32'(level), 16);
    check_output("drop_overflow", 32'(overflow), 1);
    check_output("drop_head", 32'(out_addr), 0);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_output("drain_addr", 32'(out_addr), 32'(i));
      check_output("drain_data", 32'(out_data), 32'hA000 + 32'(i));
      tick();
    end
    check_output("drain_level", 32'(level), 0);
    check_output("drain_valid", 32'(out_valid), 0);
    check_output("sticky_overflow", 32'(overflow), 1);

    // Reset while eight entries are buffered.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 19'h00200 + 19'(i), 16'h0100 + 16'(i), 1'b0);
      tick();
    end
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("pre_rst_level", 32'(level), 8);
    #3;
    rstn = 1'b0;
    #1;
    check_output("async_valid", 32'(out_valid), 0);
    check_output("async_level", 32'(level), 0);
    check_output("async_overflow", 32'(overflow), 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("post_rst_valid", 32'(out_valid), 0);
    end
    apply_stimulus(1'b1, 19'h00333, 16'h4321, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("first_valid", 32'(out_valid), 1);
    check_output("first_addr", 32'(out_addr), 32'h333);
    tick();
    check_output("first_gone", 32'(level), 0);

    // Concurrent push and pop at full.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 19'(i), 16'hC000 + 16'(i), 1'b0);
      tick();
    end
    check_output("full_overflow", 32'(overflow), 0);
    apply_stimulus(1'b1, 19'h00050, 16'h5555, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1);
    check_output("pp_level", 32'(level), 16);
    check_output("pp_overflow", 32'(overflow), 0);
    check_output("pp_head", 32'(out_addr), 1);
    for (int i = 1; i < 16; i++) begin
      check_output("pp_drain_addr", 32'(out_addr), 32'(i));
      tick();
    end
    check_output("pp_tail_addr", 32'(out_addr), 32'h50);
    check_output("pp_tail_data", 32'(out_data), 32'h5555);
    tick();
    check_output("pp_empty", 32'(level), 0);

    // Push and ready together while empty: no bypass, no phantom pop.
    apply_stimulus(1'b1, 19'h00077, 16'h7777, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0);
    check_output("pp0_level", 32'(level), 1);
    check_output("pp0_addr", 32'(out_addr), 32'h77);
    out_ready = 1'b1;
    tick();
    check_output("pp0_drained", 32'(level), 0);

    // Colour key behaviour.
    apply_stimulus(1'b1, 19'h00100, 16'hF81F, 1'b0);
    tick();
`ifdef FB_COLOR_KEY_EN
    check_output("key_level1", 32'(level), 0);
`else
    check_output("key_level1", 32'(level), 1);
`endif
    apply_stimulus(1'b1, 19'h00101, 16'h07E0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1);
`ifdef FB_COLOR_KEY_EN
    check_output("key_level2", 32'(level), 1);
`else
    check_output("key_level2", 32'(level), 2);
    check_output("key_first_data", 32'(out_data), 32'hF81F);
    tick();
`endif
    check_output("key_second_addr", 32'(out_addr), 32'h101);
    check_output("key_second_data", 32'(out_data), 32'h07E0);
    tick();
    check_output("key_empty", 32'(level), 0);
    check_output("key_overflow", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
